// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: flit type encodings, port indices and arbiter states.
package noc_pkg;

    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    typedef enum logic [2:0] {P_N, P_E, P_W, P_S, P_L} port_t;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    function automatic logic flit_legal(input logic [2:0] f);
        return (f == HEADER) || (f == PAYLOAD) || (f == TAIL);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of cand at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N  = 5,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  cand,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    always_comb begin
        int unsigned j;
        logic [IW-1:0] jj;
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        j      = 0;
        jj     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = IW'(j);
            if (!any && cand[jj]) begin
                any        = 1'b1;
                idx        = jj;
                onehot[jj] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/out_port_arbiter.sv
// Per-output-port arbiter: packet-locked round-robin grant, crossbar select,
// input pop strobes and downstream credit tracking with a sticky error flag.
module out_port_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned NPORTS  = 5,
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CW      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NPORTS-1:0]     req,
    input  logic [NPORTS-1:0]     valid,
    input  logic [3*NPORTS-1:0]   flit_id,
    input  logic                  credit_in,
    output logic [NPORTS-1:0]     grant,
    output logic [2:0]            sel,
    output logic [NPORTS-1:0]     pop,
    output logic                  vld_out,
    output logic [CW-1:0]         credits,
    output logic                  err
);

    localparam int unsigned SW = 3;

    arb_state_t        state;
    logic [SW-1:0]     ptr_q;
    logic              first_q;
    logic [NPORTS-1:0] cand;
    logic [2:0]        owner_flit;
    logic              pick_any;
    logic [SW-1:0]     pick_idx;
    logic [NPORTS-1:0] pick_onehot;
    logic              credits_nz;
    logic [CW-1:0]     credits_d;
    logic              credit_ovf;

    always_comb begin
        cand       = '0;
        owner_flit = '0;
        for (int i = 0; i < NPORTS; i++) begin
            cand[i] = req[i] & valid[i] & (flit_id[3*i +: 3] == HEADER);
            if (grant[i]) begin
                owner_flit = flit_id[3*i +: 3];
            end
        end
    end

    rr_pick #(
        .N  (NPORTS),
        .IW (SW)
    ) u_rr_pick (
        .cand   (cand),
        .ptr    (ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign credits_nz = (credits != '0);
    assign pop        = grant & valid & {NPORTS{credits_nz}};
    assign vld_out    = |pop;

    // Simultaneous send and return cancel; a return on a full counter is dropped.
    always_comb begin
        credits_d  = credits;
        credit_ovf = 1'b0;
        unique case ({vld_out, credit_in})
            2'b10: credits_d = credits - CW'(1);
            2'b01: begin
                if (credits == CW'(CREDITS)) begin
                    credit_ovf = 1'b1;
                end else begin
                    credits_d = credits + CW'(1);
                end
            end
            default: credits_d = credits;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            sel     <= '0;
            ptr_q   <= '0;
            first_q <= 1'b0;
            credits <= CW'(CREDITS);
            err     <= 1'b0;
        end else begin
            credits <= credits_d;
            if (credit_ovf) begin
                err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant   <= pick_onehot;
                        sel     <= pick_idx;
                        first_q <= 1'b1;
                        state   <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (vld_out) begin
                        first_q <= 1'b0;
                        // A second HEADER inside a packet, or an unknown code, is a protocol error.
                        if ((!first_q && owner_flit == HEADER) || !flit_legal(owner_flit)) begin
                            err <= 1'b1;
                        end
                        if (owner_flit == TAIL) begin
                            state <= IDLE;
                            grant <= '0;
                            ptr_q <= (sel == SW'(NPORTS - 1)) ? '0 : sel + SW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_port_arbiter.sv
// Bench for out_port_arbiter: directed vector table plus randomized packet traffic
// checked against a packet-level reference model.
module tb_out_port_arbiter;

    localparam logic [2:0] F_H = 3'b001;
    localparam logic [2:0] F_P = 3'b010;
    localparam logic [2:0] F_T = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req;
    logic [4:0]  valid;
    logic [14:0] flit_id;
    logic        credit_in;
    logic [4:0]  grant;
    logic [2:0]  sel;
    logic [4:0]  pop;
    logic        vld_out;
    logic [2:0]  credits;
    logic        err;

    int checks   = 0;
    int failures = 0;

    out_port_arbiter #(
        .NPORTS  (5),
        .CREDITS (4),
        .CW      (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .valid     (valid),
        .flit_id   (flit_id),
        .credit_in (credit_in),
        .grant     (grant),
        .sel       (sel),
        .pop       (pop),
        .vld_out   (vld_out),
        .credits   (credits),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rb;
        logic [4:0]  r;
        logic [4:0]  v;
        logic [14:0] f;
        logic        ci;
        logic [4:0]  g;
        logic [4:0]  p;
        logic [2:0]  cr;
        logic        e;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    int m_owner;
    int m_ptr;
    int m_cr;
    bit m_err;
    bit m_first;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] fl(input int port, input logic [2:0] f);
        logic [14:0] w;
        w = 15'(f);
        return w << (3 * port);
    endfunction

    function automatic int oh_idx(input logic [4:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 5; i++) if (oh[i]) r = i;
        return r;
    endfunction

    function automatic void add(input bit rb, input logic [4:0] r, input logic [4:0] v,
                                input logic [14:0] f, input logic ci, input logic [4:0] g,
                                input logic [4:0] p, input int cr, input bit e);
        vec_t x;
        x.rb = rb; x.r = r; x.v = v; x.f = f; x.ci = ci;
        x.g = g; x.p = p; x.cr = 3'(cr); x.e = e;
        vecs.push_back(x);
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cr    = 4;
        m_err   = 1'b0;
        m_first = 1'b0;
    endfunction

    task automatic do_reset();
        req = '0; valid = '0; flit_id = '0; credit_in = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_table();
        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].rb) do_reset();
            req = vecs[k].r; valid = vecs[k].v; flit_id = vecs[k].f; credit_in = vecs[k].ci;
            #1;
            chk($sformatf("v%0d grant", k), 32'(grant), 32'(vecs[k].g));
            chk($sformatf("v%0d pop", k), 32'(pop), 32'(vecs[k].p));
            chk($sformatf("v%0d vld_out", k), 32'(vld_out), 32'(vecs[k].p != 0));
            chk($sformatf("v%0d credits", k), 32'(credits), 32'(vecs[k].cr));
            chk($sformatf("v%0d err", k), 32'(err), 32'(vecs[k].e));
            if (vecs[k].g != 0) chk($sformatf("v%0d sel", k), 32'(sel), 32'(oh_idx(vecs[k].g)));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_random(input int ncyc);
        int s_len[5];
        int s_pos[5];
        int occ;
        int pick;
        logic [4:0] r, v, eg, ep;
        logic [14:0] f;
        logic [2:0] hf;
        logic ci;
        occ = 0;
        for (int i = 0; i < 5; i++) begin s_len[i] = 0; s_pos[i] = 0; end
        for (int c = 0; c < ncyc; c++) begin
            if (c == ncyc / 2) begin
                do_reset();
                model_reset();
                occ = 0;
                for (int i = 0; i < 5; i++) begin s_len[i] = 0; s_pos[i] = 0; end
            end
            r = '0; v = '0; f = '0;
            for (int i = 0; i < 5; i++) begin
                if (s_pos[i] >= s_len[i] && $urandom_range(3) == 0) begin
                    s_len[i] = $urandom_range(5, 2);
                    s_pos[i] = 0;
                end
                if (s_pos[i] < s_len[i]) begin
                    v[i] = ($urandom_range(3) != 0);
                    r[i] = ($urandom_range(4) != 0);
                    f[3*i +: 3] = (s_pos[i] == 0) ? F_H :
                                  (s_pos[i] == s_len[i] - 1) ? F_T : F_P;
                end
            end
            ci = (occ > 0) && ($urandom_range(2) == 0);
            req = r; valid = v; flit_id = f; credit_in = ci;
            #1;
            eg = (m_owner >= 0) ? 5'(1 << m_owner) : 5'b0;
            ep = (m_owner >= 0 && v[m_owner] && m_cr > 0) ? eg : 5'b0;
            chk($sformatf("r%0d grant", c), 32'(grant), 32'(eg));
            chk($sformatf("r%0d pop", c), 32'(pop), 32'(ep));
            chk($sformatf("r%0d vld_out", c), 32'(vld_out), 32'(ep != 0));
            chk($sformatf("r%0d credits", c), 32'(credits), 32'(m_cr));
            chk($sformatf("r%0d err", c), 32'(err), 32'(m_err));
            if (m_owner >= 0) chk($sformatf("r%0d sel", c), 32'(sel), 32'(m_owner));
            if (ep != 0) begin
                hf = f[3*m_owner +: 3];
                if (!m_first && hf == F_H) m_err = 1'b1;
                if (hf != F_H && hf != F_P && hf != F_T) m_err = 1'b1;
                m_first = 1'b0;
                s_pos[m_owner]++;
                occ++;
                if (hf == F_T) begin
                    m_ptr   = (m_owner + 1) % 5;
                    m_owner = -1;
                end
            end else if (m_owner < 0) begin
                for (int k = 0; k < 5; k++) begin
                    pick = (m_ptr + k) % 5;
                    if (r[pick] && v[pick] && f[3*pick +: 3] == F_H) begin
                        m_owner = pick;
                        m_first = 1'b1;
                        break;
                    end
                end
            end
            if (ep != 0 && !ci) m_cr--;
            else if (ep == 0 && ci) begin
                if (m_cr == 4) m_err = 1'b1;
                else m_cr++;
            end
            if (ci) occ--;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Idle after reset
        add(1, 5'b0, 5'b0, 15'b0, 0, 5'b0, 5'b0, 4, 0);
        for (int i = 0; i < 9; i++) add(0, 5'b0, 5'b0, 15'b0, 0, 5'b0, 5'b0, 4, 0);
        // Single requester E: 3-flit packet, then credits returned
        add(0, 5'b00010, 5'b00010, fl(1, F_H), 0, 5'b00000, 5'b00000, 4, 0);
        add(0, 5'b00010, 5'b00010, fl(1, F_H), 0, 5'b00010, 5'b00010, 4, 0);
        add(0, 5'b00010, 5'b00010, fl(1, F_P), 0, 5'b00010, 5'b00010, 3, 0);
        add(0, 5'b00010, 5'b00010, fl(1, F_T), 0, 5'b00010, 5'b00010, 2, 0);
        add(0, 5'b0, 5'b0, 15'b0, 1, 5'b0, 5'b0, 1, 0);
        add(0, 5'b0, 5'b0, 15'b0, 1, 5'b0, 5'b0, 2, 0);
        add(0, 5'b0, 5'b0, 15'b0, 1, 5'b0, 5'b0, 3, 0);
        add(0, 5'b0, 5'b0, 15'b0, 0, 5'b0, 5'b0, 4, 0);
        // ptr now 2: S wins over E
        add(0, 5'b01010, 5'b01010, fl(1, F_H) | fl(3, F_H), 0, 5'b00000, 5'b00000, 4, 0);
        add(0, 5'b01010, 5'b01010, fl(1, F_H) | fl(3, F_H), 0, 5'b01000, 5'b01000, 4, 0);
        // Contention N, W, L from ptr 0
        add(1, 5'b10101, 5'b10101, fl(0, F_H) | fl(2, F_H) | fl(4, F_H), 0, 5'b00000, 5'b00000, 4, 0);
        add(0, 5'b10101, 5'b10101, fl(0, F_H) | fl(2, F_H) | fl(4, F_H), 0, 5'b00001, 5'b00001, 4, 0);
        add(0, 5'b10101, 5'b10101, fl(0, F_T) | fl(2, F_H) | fl(4, F_H), 0, 5'b00001, 5'b00001, 3, 0);
        add(0, 5'b10100, 5'b10100, fl(2, F_H) | fl(4, F_H), 1, 5'b00000, 5'b00000, 2, 0);
        add(0, 5'b10100, 5'b10100, fl(2, F_H) | fl(4, F_H), 1, 5'b00100, 5'b00100, 3, 0);
        add(0, 5'b10100, 5'b10100, fl(2, F_T) | fl(4, F_H), 1, 5'b00100, 5'b00100, 3, 0);
        add(0, 5'b10000, 5'b10000, fl(4, F_H), 1, 5'b00000, 5'b00000, 3, 0);
        add(0, 5'b10000, 5'b10000, fl(4, F_H), 0, 5'b10000, 5'b10000, 4, 0);
        add(0, 5'b10000, 5'b10000, fl(4, F_T), 0, 5'b10000, 5'b10000, 3, 0);
        add(0, 5'b0, 5'b0, 15'b0, 0, 5'b0, 5'b0, 2, 0);
        // Credit stall: 6-flit packet from N
        add(1, 5'b00001, 5'b00001, fl(0, F_H), 0, 5'b00000, 5'b00000, 4, 0);
        add(0, 5'b00001, 5'b00001, fl(0, F_H), 0, 5'b00001, 5'b00001, 4, 0);
        add(0, 5'b00001, 5'b00001, fl(0, F_P), 0, 5'b00001, 5'b00001, 3, 0);
        add(0, 5'b00001, 5'b00001, fl(0, F_P), 0, 5'b00001, 5'b00001, 2, 0);
        add(0, 5'b00001, 5'b00001, fl(0, F_P), 0, 5'b00001, 5'b00001, 1, 0);
        add(0, 5'b00001, 5'b00001, fl(0, F_P), 0, 5'b00001, 5'b00000, 0, 0);
        add(0, 5'b00001, 5'b00001, fl(0, F_P), 0, 5'b00001, 5'b00000, 0, 0);
        add(0, 5'b00001, 5'b00001, fl(0, F_P), 1, 5'b00001, 5'b00000, 0, 0);
        add(0, 5'b00001, 5'b00001, fl(0, F_P), 0, 5'b00001, 5'b00001, 1, 0);
        add(0, 5'b00001, 5'b00001, fl(0, F_T), 0, 5'b00001, 5'b00000, 0, 0);
        add(0, 5'b00001, 5'b00001, fl(0, F_T), 1, 5'b00001, 5'b00000, 0, 0);
        add(0, 5'b00001, 5'b00001, fl(0, F_T), 1, 5'b00001, 5'b00001, 1, 0);
        add(0, 5'b0, 5'b0, 15'b0, 0, 5'b0, 5'b0, 1, 0);
        // Credit overflow, then mid-packet HEADER; err sticky until reset
        add(1, 5'b0, 5'b0, 15'b0, 1, 5'b0, 5'b0, 4, 0);
        add(0, 5'b0, 5'b0, 15'b0, 0, 5'b0, 5'b0, 4, 1);
        add(0, 5'b0, 5'b0, 15'b0, 0, 5'b0, 5'b0, 4, 1);
        add(1, 5'b00001, 5'b00001, fl(0, F_H), 0, 5'b00000, 5'b00000, 4, 0);
        add(0, 5'b00001, 5'b00001, fl(0, F_H), 0, 5'b00001, 5'b00001, 4, 0);
        add(0, 5'b00001, 5'b00001, fl(0, F_P), 0, 5'b00001, 5'b00001, 3, 0);
        add(0, 5'b00001, 5'b00001, fl(0, F_H), 0, 5'b00001, 5'b00001, 2, 0);
        add(0, 5'b00001, 5'b00001, fl(0, F_T), 0, 5'b00001, 5'b00001, 1, 1);
        add(0, 5'b0, 5'b0, 15'b0, 0, 5'b0, 5'b0, 0, 1);
        add(0, 5'b0, 5'b0, 15'b0, 0, 5'b0, 5'b0, 0, 1);
        add(1, 5'b0, 5'b0, 15'b0, 0, 5'b0, 5'b0, 4, 0);
        // Reset mid-packet after ptr moved to 2; arbitration restarts from ptr 0
        add(1, 5'b00010, 5'b00010, fl(1, F_H), 0, 5'b00000, 5'b00000, 4, 0);
        add(0, 5'b00010, 5'b00010, fl(1, F_H), 0, 5'b00010, 5'b00010, 4, 0);
        add(0, 5'b00010, 5'b00010, fl(1, F_T), 0, 5'b00010, 5'b00010, 3, 0);
        add(0, 5'b01000, 5'b01000, fl(3, F_H), 0, 5'b00000, 5'b00000, 2, 0);
        add(0, 5'b01000, 5'b01000, fl(3, F_H), 0, 5'b01000, 5'b01000, 2, 0);
        add(0, 5'b01000, 5'b01000, fl(3, F_P), 0, 5'b01000, 5'b01000, 1, 0);
        add(1, 5'b01001, 5'b01001, fl(0, F_H) | fl(3, F_H), 0, 5'b00000, 5'b00000, 4, 0);
        add(0, 5'b01001, 5'b01001, fl(0, F_H) | fl(3, F_H), 0, 5'b00001, 5'b00001, 4, 0);

        run_table();

        do_reset();
        model_reset();
        run_random(600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
